// File: rtl/quadrature_emulator_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Phase encodings are {A,B}; forward order is 00,10,11,01.
package quadrature_emulator_pkg;

  localparam int ENCODER_MAX_DEF = 64000;
  localparam int MIN_PERIOD_DEF  = 4;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic {
    IDLE,
    MOVE
  } state_t;

  typedef enum logic {
    DIR_FWD,
    DIR_REV
  } dir_t;

  function automatic logic [1:0] next_phase(
    input logic [1:0] ph,
    input dir_t       dir
  );
    logic [1:0] nx;
    nx = PH_00;
    unique case (1'b1)
      (ph == PH_00): nx = (dir == DIR_FWD) ? PH_10 : PH_01;
      (ph == PH_10): nx = (dir == DIR_FWD) ? PH_11 : PH_00;
      (ph == PH_11): nx = (dir == DIR_FWD) ? PH_01 : PH_10;
      (ph == PH_01): nx = (dir == DIR_FWD) ? PH_00 : PH_11;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quadrature_emulator_step_timer.sv
// Period counter: tick fires on the last cycle of each period.
// Holding clear discards any partial period.
module step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  assign tick = !clear
    && (count == period - PERIOD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/quadrature_emulator.sv
// Quadrature A/B generator that walks the shortest path to a
// commanded position, one edge per programmable period.
module quadrature_emulator
  import quadrature_emulator_pkg::*;
#(
  parameter int ENCODER_MAX = ENCODER_MAX_DEF,
  parameter int PERIOD_W    = 24,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_target,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                A,
  output logic                B,
  output logic [15:0]         position,
  output logic                busy,
  output logic                done
);

  localparam logic [15:0] POS_MAX =
    16'(ENCODER_MAX - 1);
  localparam logic [16:0] MOD =
    17'(ENCODER_MAX);
  localparam logic [16:0] HALF =
    17'(ENCODER_MAX / 2);
  localparam logic [PERIOD_W-1:0] PMIN =
    PERIOD_W'(MIN_PERIOD);

  state_t              state;
  dir_t                dir;
  logic [15:0]         target;
  logic [PERIOD_W-1:0] period;
  logic [1:0]          phase;

  logic [15:0]         tgt_in;
  logic [16:0]         diff;
  logic [PERIOD_W-1:0] eff_period;
  logic [15:0]         pos_next;
  logic                accept;
  logic                arrive;
  logic                tick;
  logic                timer_clear;

  assign A = phase[1];
  assign B = phase[0];

  assign tgt_in = 16'(32'(cmd_target)
    % 32'(ENCODER_MAX));

  assign eff_period = (cmd_period < PMIN)
    ? PMIN : cmd_period;

  assign accept = cmd_valid && cmd_ready;

  // Distance forward around the ring.
  always_comb begin
    diff = '0;
    if (tgt_in >= position) begin
      diff = 17'(tgt_in) - 17'(position);
    end else begin
      diff = 17'(tgt_in) + MOD - 17'(position);
    end
  end

  always_comb begin
    pos_next = position;
    unique case (dir)
      DIR_FWD: pos_next = (position == POS_MAX)
        ? 16'd0 : position + 16'd1;
      DIR_REV: pos_next = (position == 16'd0)
        ? POS_MAX : position - 16'd1;
    endcase
  end

  assign arrive = (pos_next == target);

  assign timer_clear = (state != MOVE) || abort;

  step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir       <= DIR_FWD;
      target    <= '0;
      period    <= '0;
      phase     <= PH_00;
      position  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            target <= tgt_in;
            period <= eff_period;
            if (diff == 17'd0) begin
              done <= 1'b1;
            end else begin
              dir <= (diff <= HALF)
                ? DIR_FWD : DIR_REV;
              state     <= MOVE;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        MOVE: begin
          // Final edge beats a coincident abort.
          if (tick && arrive) begin
            phase     <= next_phase(phase, dir);
            position  <= pos_next;
            state     <= IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (tick) begin
            phase    <= next_phase(phase, dir);
            position <= pos_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_emulator.sv
// Directed bench for quadrature_emulator with an edge scoreboard
// and an independent loop-back quadrature decoder.
module tb_quadrature_emulator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_target;
  logic [23:0] cmd_period;
  logic        abort;
  logic        A;
  logic        B;
  logic [15:0] position;
  logic        busy;
  logic        done;

  quadrature_emulator #(
    .ENCODER_MAX (64000),
    .PERIOD_W    (24),
    .MIN_PERIOD  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_period (cmd_period),
    .abort      (abort),
    .A          (A),
    .B          (B),
    .position   (position),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  ab;
    logic [15:0] pos;
    logic        last;
  } exp_t;

  exp_t sbq[$];

  logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0]  m_ab;
  int unsigned m_pos;

  // Loop-back decoder: counts transitions of the emulated encoder.
  logic [1:0]  dec_prev;
  int unsigned dec_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_prev <= 2'b00;
      dec_cnt  <= 0;
    end else if ({A, B} != dec_prev) begin
      dec_prev <= {A, B};
      case ({dec_prev, A, B})
        4'b0010, 4'b1011, 4'b1101, 4'b0100:
          dec_cnt <= (dec_cnt + 1) % 64000;
        default:
          dec_cnt <= (dec_cnt + 63999) % 64000;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  task automatic to_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int ab_index(input logic [1:0] ab);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++)
      if (seq[i] == ab) r = i;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ab", {A, B}, 0);
    chk("rst_async_pos", position, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", cmd_ready, 1);
    chk("rst_async_done", done, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_ab", {A, B}, 0);
    chk("rst_hold_pos", position, 0);
    chk("rst_hold_done", done, 0);
    rst_n = 1'b1;
    m_ab  = 2'b00;
    m_pos = 0;
  endtask

  task automatic issue(input logic [15:0] tgt,
                       input logic [23:0] per,
                       output int unsigned acc);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_period = per;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic plan(input int unsigned acc,
                      input int unsigned tgt,
                      input int unsigned per,
                      input int unsigned max_edges);
    int unsigned t, d, steps, eff;
    bit fwd;
    int idx;
    exp_t e;
    t     = tgt % 64000;
    d     = (t + 64000 - m_pos) % 64000;
    fwd   = (d <= 32000);
    steps = fwd ? d : 64000 - d;
    eff   = (per < 4) ? 4 : per;
    for (int unsigned k = 1; k <= steps && k <= max_edges; k++) begin
      idx   = ab_index(m_ab);
      idx   = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
      m_ab  = seq[idx];
      m_pos = fwd ? (m_pos + 1) % 64000 : (m_pos + 63999) % 64000;
      e.cyc  = acc + k * eff;
      e.ab   = m_ab;
      e.pos  = 16'(m_pos);
      e.last = (k == steps);
      sbq.push_back(e);
    end
  endtask

  task automatic run_sb(input logic [1:0] start_ab);
    exp_t e;
    logic [1:0] prev;
    prev = start_ab;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      to_cyc(e.cyc - 1);
      chk("ab_before_edge", {A, B}, prev);
      chk("busy_mid", busy, 1);
      to_cyc(e.cyc);
      chk("ab_edge", {A, B}, e.ab);
      chk("pos_edge", position, e.pos);
      chk("done_edge", done, e.last);
      if (e.last) begin
        chk("busy_end", busy, 0);
        to_cyc(e.cyc + 1);
        chk("done_clear", done, 0);
        chk("ready_end", cmd_ready, 1);
      end
      prev = e.ab;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned acc;
    logic [1:0] ab0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_period = '0;
    abort      = 1'b0;
    m_ab       = 2'b00;
    m_pos      = 0;

    do_reset();

    // Forward 0 -> 4, period 10
    @(negedge clk);
    ab0 = m_ab;
    issue(16'd4, 24'd10, acc);
    plan(acc, 4, 10, 100);
    run_sb(ab0);
    chk("fwd_pos", position, 4);
    chk("fwd_decoder", dec_cnt, 4);

    // Reverse wrap 0 -> 63998, period 4
    do_reset();
    @(negedge clk);
    ab0 = m_ab;
    issue(16'd63998, 24'd4, acc);
    plan(acc, 63998, 4, 100);
    run_sb(ab0);
    chk("rev_pos", position, 63998);
    chk("rev_decoder", dec_cnt, 63998);

    // Period clamp: period 1 behaves as 4
    do_reset();
    @(negedge clk);
    ab0 = m_ab;
    issue(16'd3, 24'd1, acc);
    plan(acc, 3, 1, 100);
    run_sb(ab0);
    chk("clamp_pos", position, 3);

    // Move to 7, then null move to 7
    @(negedge clk);
    ab0 = m_ab;
    issue(16'd7, 24'd4, acc);
    plan(acc, 7, 4, 100);
    run_sb(ab0);
    @(negedge clk);
    issue(16'd7, 24'd9, acc);
    chk("null_done", done, 1);
    chk("null_busy", busy, 0);
    chk("null_ab", {A, B}, m_ab);
    chk("null_pos", position, 7);
    to_cyc(acc + 1);
    chk("null_done_clr", done, 0);
    chk("null_busy2", busy, 0);
    chk("null_ready", cmd_ready, 1);

    // Abort after two edges; command while busy ignored
    do_reset();
    @(negedge clk);
    ab0 = m_ab;
    issue(16'd100, 24'd5, acc);
    plan(acc, 100, 5, 2);
    to_cyc(acc + 2);
    chk("busy_ready_low", cmd_ready, 0);
    cmd_valid  = 1'b1;
    cmd_target = 16'd50;
    cmd_period = 24'd4;
    to_cyc(acc + 3);
    cmd_valid = 1'b0;
    run_sb(ab0);
    abort = 1'b1;
    to_cyc(acc + 11);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_pos", position, 2);
    chk("abort_ab", {A, B}, 2'b11);
    to_cyc(acc + 16);
    chk("abort_hold_pos", position, 2);
    chk("abort_hold_ab", {A, B}, 2'b11);
    chk("abort_hold_done", done, 0);

    // Asynchronous reset in the middle of a move
    @(negedge clk);
    issue(16'd50, 24'd4, acc);
    to_cyc(acc + 9);
    chk("mid_busy", busy, 1);
    do_reset();
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_emulator.md
Name: quadrature_emulator

Overview:
- Generates quadrature A/B signals that mimic a motor shaft encoder.
- Drives a commanded number of edges toward a target count at a programmable edge rate.
- Used for hardware-in-the-loop checks of the encoder decoder path. It loops back onto the PITCH/YAW encoder inputs in place of the real motor encoders.
- Its internal position follows the same wrap rules as the decoder, so the decoded count must match `position` exactly.

Parameters:
- ENCODER_MAX, 64000: position modulus; position range is 0..ENCODER_MAX-1.
- PERIOD_W, 24: width of the edge-period command.
- MIN_PERIOD, 4: minimum clk cycles between A/B edges (decoder synchroniser margin).

Ports:
- clk  in  1  system clock (50 MHz fabric clock).
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_target  in  16  target position, must be < ENCODER_MAX.
- cmd_period  in  PERIOD_W  clk cycles per quadrature edge.
- abort  in  1  stop the current move immediately.
- A  out  1  quadrature channel A (registered).
- B  out  1  quadrature channel B (registered).
- position  out  16  current emulated count.
- busy  out  1  high while in MOVE.
- done  out  1  one-cycle pulse when the target is reached.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values:
  - A=0, B=0, position=0.
  - Phase 00, state IDLE.
  - cmd_ready=1, busy=0, done=0.
  - Period counter 0.
- Phase sequence {A,B}:
  - Forward (A leads): 00→10→11→01→00.
  - Reverse: 00→01→11→10→00.
  - Exactly one of A/B changes per step.
- Position arithmetic:
  - Forward: position+1, wrapping ENCODER_MAX-1→0.
  - Reverse: position-1, wrapping 0→ENCODER_MAX-1.
- FSM states: IDLE, MOVE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch the target and the effective period = max(cmd_period, MIN_PERIOD).
  - Compute diff = (target - position) mod ENCODER_MAX.
  - diff==0: done=1 on the next cycle, stay IDLE, A/B unchanged.
  - 0 < diff ≤ ENCODER_MAX/2: direction forward.
  - Otherwise: direction reverse (shortest path; exact half goes forward).
  - Go to MOVE with period counter cleared.
- MOVE:
  - cmd_ready=0, busy=1.
  - Period counter increments each cycle.
  - When counter==period-1: clear the counter, advance phase, update position.
  - The first A/B edge appears exactly `period` cycles after the accept edge; later edges follow every `period` cycles.
- Completion: when the updated position equals the target, return to IDLE in the same edge. done=1 for that one cycle, busy=0, and cmd_ready=1 the following cycle.
- abort:
  - In MOVE: go to IDLE next cycle. A/B and position hold their last values, no done pulse, any partial period is discarded.
  - In IDLE: ignored.
- Simultaneous events:
  - cmd_valid while busy is ignored (no queue).
  - abort in the same cycle as the final edge: completion wins and done pulses.
- Invalid target: cmd_target ≥ ENCODER_MAX is reduced mod ENCODER_MAX on latch.
- Reset mid-move: all outputs return to reset values asynchronously; no done pulse.
- Latency: accept→first edge = period cycles. Total move = |steps|·period cycles.

Decomposition:
- Shared package:
  - ENCODER_MAX default, MIN_PERIOD.
  - Phase encoding constants PH_00/PH_10/PH_11/PH_01.
  - State enum {IDLE, MOVE}.
  - Direction enum.
- Sub-module step_timer: loadable period counter. Inputs: clear and period. Output: one-cycle `tick`. Parameterised by PERIOD_W.
- The FSM, phase and position logic stay in quadrature_emulator.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-stream → A=0, B=0, position=0, cmd_ready=1, busy=0, done=0; check assertion is asynchronous (mid-cycle).
- Forward move from 0, target=4, period=10 → AB = 10, 11, 01, 00 at cycles +10, +20, +30, +40 after accept; position=4; done pulse at +40; Encoder instance looped back reads count 4.
- Wrap reverse from 0, target=63998, period=4 → reverse chosen; AB = 01, 11 at +4, +8; position 63999 then 63998; done at +8.
- Period clamp: target=3, period=1 → edges exactly 4 cycles apart; position=3 after 12 cycles.
- Null move: target equals position (7) → done pulse one cycle after accept, no A/B change, busy never high.
- Abort and busy-ignore: target=100, period=5; cmd_valid during busy ignored; abort after 2 edges → position=2, AB=11 held, no done, cmd_ready=1 next cycle.
